nand3_bist: RTL and testbench

Built-in self-test engine for the `nand3_nbit` gate array: the driving and checking end of its three-input interface. It generates pseudo-random vectors on `dut_in0/1/2`, samples `dut_out`, and compares each sample against the locally computed expected value `~(in0 & in1 & in2)`. It reports pass/fail, a saturating error count and the index of the first failing vector. It sits beside any N-bit NAND3 datapath slice and replaces hand-written stimulus benches during bring-up.

---
 rtl/nand3_bist.sv | 126 ++++++++++++
 tb/tb_nand3_bist.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nand3_bist.sv
// nand3_bist: drives LFSR vectors into an N-bit NAND3 array and checks its
// combinational response, reporting pass/fail, an error count and the index
// of the first failing vector.
//
// state  | meaning
// IDLE   | waiting for start, dut_in* held at zero
// RUN    | one vector compared per clock, next vector driven
// DONE   | results valid, dut_in* hold the last vector
module nand3_bist #(
  parameter int          N      = 8,
  parameter int          CYCLES = 256,
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          ERRW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N-1:0]    dut_in0,
  output logic [N-1:0]    dut_in1,
  output logic [N-1:0]    dut_in2,
  input  logic [N-1:0]    dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic [15:0]     first_fail_idx
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_RUN  = 2'd1;
  localparam logic [1:0]  S_DONE = 2'd2;
  localparam logic [15:0] LAST   = 16'(CYCLES - 1);

  logic [1:0]      state;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_next;
  logic [15:0]     idx;
  logic            ff_seen;
  logic [N-1:0]    expected;
  logic            mismatch;
  logic [ERRW-1:0] err_next;

  // Bit i of the returned vector is LFSR bit (i+off) mod 16; wraps for N > 16.
  function automatic logic [N-1:0] vec_map(input logic [15:0] s, input int off);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      v[i] = s[4'((i + off) % 16)];
    end
    return v;
  endfunction

  // LFSR step, expected response, and saturating error count for this edge
  always_comb begin
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    expected  = ~(dut_in0 & dut_in1 & dut_in2);
    mismatch  = (dut_out != expected);
    err_next  = err_count;
    if (mismatch && !(&err_count)) begin
      err_next = err_count + 1'b1;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Sequencer: start loads vector 0, RUN compares and advances, abort drops to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      lfsr           <= SEED;
      idx            <= '0;
      ff_seen        <= 1'b0;
      dut_in0        <= '0;
      dut_in1        <= '0;
      dut_in2        <= '0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_RUN;
            lfsr           <= SEED;
            idx            <= '0;
            ff_seen        <= 1'b0;
            dut_in0        <= vec_map(SEED, 0);
            dut_in1        <= vec_map(SEED, 5);
            dut_in2        <= vec_map(SEED, 11);
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state   <= S_IDLE;
            dut_in0 <= '0;
            dut_in1 <= '0;
            dut_in2 <= '0;
          end else begin
            err_count <= err_next;
            if (mismatch && !ff_seen) begin
              ff_seen        <= 1'b1;
              first_fail_idx <= idx;
            end
            if (idx == LAST) begin
              state <= S_DONE;
              pass  <= (err_next == '0);
            end else begin
              idx     <= idx + 16'd1;
              lfsr    <= lfsr_next;
              dut_in0 <= vec_map(lfsr_next, 0);
              dut_in1 <= vec_map(lfsr_next, 5);
              dut_in2 <= vec_map(lfsr_next, 11);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand3_bist.sv
// Bench for nand3_bist: three instances (N=4/16 vectors, N=8/256 vectors,
// N=8/8 vectors with a 2-bit error counter) each with a NAND3 model whose
// output the bench can corrupt.
module tb_nand3_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // instance A: N=4, CYCLES=16
  logic       start_a = 1'b0, abort_a = 1'b0;
  logic [3:0] in0_a, in1_a, in2_a, out_a, flip_a;
  logic       busy_a, done_a, pass_a;
  logic [15:0] err_a, ffi_a;

  // instance B: N=8, CYCLES=256
  logic       start_b = 1'b0;
  logic [7:0] in0_b, in1_b, in2_b, out_b;
  logic       busy_b, done_b, pass_b;
  logic [15:0] err_b, ffi_b;

  // instance C: N=8, CYCLES=8, ERRW=2
  logic       start_c = 1'b0, inv_c;
  logic [7:0] in0_c, in1_c, in2_c, out_c;
  logic       busy_c, done_c, pass_c;
  logic [1:0] err_c;
  logic [15:0] ffi_c;

  assign out_a = ~(in0_a & in1_a & in2_a) ^ flip_a;
  assign out_b = ~(in0_b & in1_b & in2_b);
  assign out_c = ~(in0_c & in1_c & in2_c) ^ {8{inv_c}};

  nand3_bist #(.N(4), .CYCLES(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .dut_in0(in0_a), .dut_in1(in1_a), .dut_in2(in2_a), .dut_out(out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail_idx(ffi_a));

  nand3_bist #(.N(8), .CYCLES(256)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0),
    .dut_in0(in0_b), .dut_in1(in1_b), .dut_in2(in2_b), .dut_out(out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail_idx(ffi_b));

  nand3_bist #(.N(8), .CYCLES(8), .ERRW(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(1'b0),
    .dut_in0(in0_c), .dut_in1(in1_c), .dut_in2(in2_c), .dut_out(out_c),
    .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_count(err_c), .first_fail_idx(ffi_c));

  typedef struct {
    logic [3:0] in0;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [3:0] out;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance one edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a();
    @(negedge clk);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int limit);
    for (int i = 0; i < limit && !done_a; i++) step();
  endtask

  task automatic wait_done_c(input int limit);
    for (int i = 0; i < limit && !done_c; i++) step();
  endtask

  initial begin
    int nbusy;
    // hand-derived N=4 vectors from SEED ACE1 -> 59C3 -> B387 -> 670F
    tbl[0] = '{4'h1, 4'h7, 4'h5, 4'hE};
    tbl[1] = '{4'h3, 4'hE, 4'hB, 4'hD};
    tbl[2] = '{4'h7, 4'hC, 4'h6, 4'hB};
    tbl[3] = '{4'hF, 4'h8, 4'hC, 4'h7};
    flip_a = 4'h0;
    inv_c  = 1'b0;

    // reset state
    #12;
    chk("rst_in0", 32'(in0_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_pass", 32'(pass_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_ffi", 32'(ffi_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // golden vectors 0..3
    pulse_a();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("gold_in0_%0d", k), 32'(in0_a), 32'(tbl[k].in0));
      chk($sformatf("gold_in1_%0d", k), 32'(in1_a), 32'(tbl[k].in1));
      chk($sformatf("gold_in2_%0d", k), 32'(in2_a), 32'(tbl[k].in2));
      chk($sformatf("gold_out_%0d", k), 32'(out_a), 32'(tbl[k].out));
      chk($sformatf("gold_busy_%0d", k), 32'(busy_a), 1);
      step();
    end
    chk("gold_pass_mid", 32'(pass_a), 0);
    wait_done_a(40);
    chk("gold_done", 32'(done_a), 1);
    chk("gold_pass", 32'(pass_a), 1);
    chk("gold_err", 32'(err_a), 0);

    // single fault on vector 5
    pulse_a();
    repeat (5) step();
    flip_a = 4'b0100;
    step();
    flip_a = 4'h0;
    chk("sf_err_mid", 32'(err_a), 1);
    chk("sf_pass_mid", 32'(pass_a), 0);
    wait_done_a(40);
    chk("sf_done", 32'(done_a), 1);
    chk("sf_err", 32'(err_a), 1);
    chk("sf_ffi", 32'(ffi_a), 5);
    chk("sf_pass", 32'(pass_a), 0);

    // fault on the last vector lands on the same edge done rises
    pulse_a();
    repeat (15) step();
    chk("last_busy", 32'(busy_a), 1);
    flip_a = 4'b0001;
    step();
    flip_a = 4'h0;
    chk("last_done", 32'(done_a), 1);
    chk("last_err", 32'(err_a), 1);
    chk("last_ffi", 32'(ffi_a), 15);
    chk("last_pass", 32'(pass_a), 0);

    // fault on vector 2, abort at vector 10
    pulse_a();
    repeat (2) step();
    flip_a = 4'b1000;
    step();
    flip_a = 4'h0;
    repeat (7) step();
    @(negedge clk);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("ab_busy", 32'(busy_a), 0);
    chk("ab_done", 32'(done_a), 0);
    chk("ab_in", 32'({in0_a, in1_a, in2_a}), 0);
    chk("ab_err_hold", 32'(err_a), 1);
    chk("ab_ffi_hold", 32'(ffi_a), 2);
    repeat (3) step();
    chk("ab_idle_hold", 32'({busy_a, done_a, pass_a}), 0);

    // full run after abort starts from vector 0
    pulse_a();
    chk("ab_re_in", 32'({in0_a, in1_a, in2_a}), 32'({tbl[0].in0, tbl[0].in1, tbl[0].in2}));
    chk("ab_re_err", 32'(err_a), 0);
    nbusy = 0;
    for (int i = 0; i < 40 && !done_a; i++) begin
      if (busy_a) nbusy++;
      step();
    end
    chk("ab_re_busy_cycles", 32'(nbusy), 16);
    chk("ab_re_pass", 32'(pass_a), 1);

    // asynchronous reset at vector 3 after a fault on vector 1
    pulse_a();
    step();
    flip_a = 4'b0010;
    step();
    flip_a = 4'h0;
    step();
    chk("rr_err_pre", 32'(err_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_busy", 32'(busy_a), 0);
    chk("rr_in", 32'({in0_a, in1_a, in2_a}), 0);
    chk("rr_err", 32'(err_a), 0);
    chk("rr_ffi", 32'(ffi_a), 0);
    chk("rr_done_pass", 32'({done_a, pass_a}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // clean 256-vector run on N=8
    @(negedge clk);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b_in0_v0", 32'(in0_b), 32'h00E1);
    chk("b_in1_v0", 32'(in1_b), 32'h0067);
    chk("b_in2_v0", 32'(in2_b), 32'h0035);
    nbusy = 0;
    for (int i = 0; i < 400 && !done_b; i++) begin
      if (busy_b) nbusy++;
      step();
    end
    chk("b_busy_cycles", 32'(nbusy), 256);
    chk("b_done", 32'(done_b), 1);
    chk("b_pass", 32'(pass_b), 1);
    chk("b_err", 32'(err_b), 0);
    chk("b_ffi", 32'(ffi_b), 0);

    // saturation with every vector wrong
    inv_c = 1'b1;
    @(negedge clk);
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    wait_done_c(30);
    chk("c_done", 32'(done_c), 1);
    chk("c_err_sat", 32'(err_c), 3);
    chk("c_pass", 32'(pass_c), 0);
    chk("c_ffi", 32'(ffi_c), 0);
    repeat (4) step();
    chk("c_hold", 32'({done_c, pass_c, err_c}), 32'b1011);

    // restart from DONE with a correct DUT
    inv_c = 1'b0;
    @(negedge clk);
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    chk("c_re_clear", 32'({busy_c, done_c, err_c}), 32'b1000);
    wait_done_c(30);
    chk("c_re_done", 32'(done_c), 1);
    chk("c_re_pass", 32'(pass_c), 1);
    chk("c_re_err", 32'(err_c), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
